// File: rtl/opcodes.sv
// Opcode map, ALU/PC select encodings, FSM states and the decoded control word.
// HALT exists only when ILLEGAL_TRAP_EN is defined (unknown opcodes trap instead of acting as NOP).
package opcodes;

  typedef enum logic [2:0] {
    FnACC = 3'd0,
    FnADD = 3'd1,
    FnSUB = 3'd2,
    FnAND = 3'd3,
    FnOR  = 3'd4,
    FnXOR = 3'd5
  } alu_functions_t;

  typedef enum logic [1:0] {
    Lr    = 2'd0,
    Pc1   = 2'd1,
    PcRel = 2'd2,
    PcAbs = 2'd3
  } pc_select_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
`ifdef ILLEGAL_TRAP_EN
    , HALT = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    ImmNone = 2'd0,
    Imm5    = 2'd1,
    Imm8    = 2'd2
  } imm_src_t;

  localparam logic [4:0] OpNop   = 5'b00000;
  localparam logic [4:0] OpAdd   = 5'b00101;
  localparam logic [4:0] OpAddi  = 5'b00110;
  localparam logic [4:0] OpAdc   = 5'b00111;
  localparam logic [4:0] OpAdci  = 5'b01000;
  localparam logic [4:0] OpAddib = 5'b01001;

  typedef struct packed {
    alu_functions_t aluFn;
    pc_select_t     pcSel;
    imm_src_t       immSrc;
    logic           immSel;
    logic           regWe;
    logic           flagsWe;
    logic           cinUse;
    logic           pcWe;
    logic           raFromRd;
    logic           illegal;
  } ctrl_t;

  localparam ctrl_t NopCtrl = '{
    aluFn: FnACC, pcSel: Pc1, immSrc: ImmNone, immSel: 1'b0, regWe: 1'b0,
    flagsWe: 1'b0, cinUse: 1'b0, pcWe: 1'b1, raFromRd: 1'b0, illegal: 1'b0
  };

  localparam ctrl_t AddCtrl = '{
    aluFn: FnADD, pcSel: Pc1, immSrc: ImmNone, immSel: 1'b0, regWe: 1'b1,
    flagsWe: 1'b1, cinUse: 1'b0, pcWe: 1'b1, raFromRd: 1'b0, illegal: 1'b0
  };

  // A trapped instruction writes nothing, including the PC.
  localparam ctrl_t TrapCtrl = '{
    aluFn: FnACC, pcSel: Lr, immSrc: ImmNone, immSel: 1'b0, regWe: 1'b0,
    flagsWe: 1'b0, cinUse: 1'b0, pcWe: 1'b0, raFromRd: 1'b0, illegal: 1'b1
  };

endpackage

// File: rtl/instr_decoder_if.sv
// Instruction fetch handshake: decoder (master) raises mem_req, bus (slave) answers with mem_ack + instr.
// No backpressure beyond the request being held until acknowledged.
interface instr_decoder_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] instr;

  modport master (output mem_req, input mem_ack, input instr);
  modport slave  (input mem_req, output mem_ack, output instr);
endinterface

// File: rtl/instr_decode_rom.sv
// Combinational opcode-to-control-word table; zero latency, no handshake.
// Unknown opcodes map to TrapCtrl with ILLEGAL_TRAP_EN defined, otherwise to NopCtrl.
module instr_decode_rom
  import opcodes::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = NopCtrl;
    case (opcode)
      OpNop: ctrl = NopCtrl;
      OpAdd: ctrl = AddCtrl;
      OpAddi: begin
        ctrl        = AddCtrl;
        ctrl.immSel = 1'b1;
        ctrl.immSrc = Imm5;
      end
      OpAdc: begin
        ctrl        = AddCtrl;
        ctrl.cinUse = 1'b1;
      end
      OpAdci: begin
        ctrl        = AddCtrl;
        ctrl.immSel = 1'b1;
        ctrl.immSrc = Imm5;
        ctrl.cinUse = 1'b1;
      end
      OpAddib: begin
        // Two-operand immediate form: the destination doubles as source A.
        ctrl          = AddCtrl;
        ctrl.immSel   = 1'b1;
        ctrl.immSrc   = Imm8;
        ctrl.raFromRd = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        ctrl = TrapCtrl;
`else
        ctrl = NopCtrl;
`endif
      end
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Multi-cycle fetch/decode/execute sequencer: EXEC follows the mem_ack cycle by 2 cycles; writes pulse for 1 cycle in EXEC.
// mem_req is held until mem_ack; ILLEGAL_TRAP_EN makes unknown opcodes halt (HALT, exit only via Reset).
module instr_decoder
  import opcodes::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  instr_decoder_if.master   fetchBus,
  output alu_functions_t    alu_fn,
  output pc_select_t        pc_sel,
  output logic              pc_we,
  output logic [2:0]        rd,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic              reg_we,
  output logic              flags_we,
  output logic              cin_use,
  output logic              illegal
);

  state_t            state;
  state_t            nextState;
  logic [DATA_W-1:0] ir;
  ctrl_t             romCtrl;
  logic [DATA_W-1:0] immExt;
  logic [2:0]        raSel;
  logic              regWeQ;
  logic              flagsWeQ;
  logic              pcWeQ;

  instr_decode_rom uRom (
    .opcode (ir[15:11]),
    .ctrl   (romCtrl)
  );

  always_comb begin
    immExt = '0;
    case (romCtrl.immSrc)
      Imm5:    immExt = {{(DATA_W-5){ir[4]}}, ir[4:0]};
      Imm8:    immExt = {{(DATA_W-8){ir[7]}}, ir[7:0]};
      default: immExt = '0;
    endcase
  end

  assign raSel = romCtrl.raFromRd ? ir[10:8] : ir[7:5];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState        = state;
    fetchBus.mem_req = 1'b0;
    case (state)
      FETCH: begin
        // Gated by Reset so no request leaks out while reset is still held.
        fetchBus.mem_req = ~Reset;
        if (fetchBus.mem_ack) begin
          nextState = DECODE;
        end
      end
      DECODE: nextState = EXEC;
      EXEC: begin
`ifdef ILLEGAL_TRAP_EN
        nextState = illegal ? HALT : FETCH;
`else
        nextState = FETCH;
`endif
      end
`ifdef ILLEGAL_TRAP_EN
      HALT: nextState = HALT;
`endif
      default: nextState = FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir <= '0;
    end else if (state == FETCH && fetchBus.mem_ack) begin
      ir <= fetchBus.instr;
    end
  end

  // Fields and control word are registered once in DECODE and stay stable until the next DECODE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_fn   <= FnACC;
      pc_sel   <= Lr;
      rd       <= '0;
      ra       <= '0;
      rb       <= '0;
      imm      <= '0;
      imm_sel  <= 1'b0;
      cin_use  <= 1'b0;
      illegal  <= 1'b0;
      regWeQ   <= 1'b0;
      flagsWeQ <= 1'b0;
      pcWeQ    <= 1'b0;
    end else if (state == DECODE) begin
      alu_fn   <= romCtrl.aluFn;
      pc_sel   <= romCtrl.pcSel;
      rd       <= ir[10:8];
      ra       <= raSel;
      rb       <= ir[4:2];
      imm      <= immExt;
      imm_sel  <= romCtrl.immSel;
      cin_use  <= romCtrl.cinUse;
      illegal  <= romCtrl.illegal;
      regWeQ   <= romCtrl.regWe;
      flagsWeQ <= romCtrl.flagsWe;
      pcWeQ    <= romCtrl.pcWe;
    end
  end

  assign reg_we   = regWeQ   & (state == EXEC);
  assign flags_we = flagsWeQ & (state == EXEC);
  assign pc_we    = pcWeQ    & (state == EXEC);

endmodule

// File: tb/tb_instr_decoder.sv
// Directed-vector bench for instr_decoder: fetch handshake, decode table, reset override, unknown opcodes.
// Build with or without ILLEGAL_TRAP_EN; the unknown-opcode expectations follow the macro.
module tb_instr_decoder;
  import opcodes::*;

  logic           Clock = 1'b0;
  logic           Reset;
  alu_functions_t alu_fn;
  pc_select_t     pc_sel;
  logic           pc_we;
  logic [2:0]     rd;
  logic [2:0]     ra;
  logic [2:0]     rb;
  logic [15:0]    imm;
  logic           imm_sel;
  logic           reg_we;
  logic           flags_we;
  logic           cin_use;
  logic           illegal;

  int checks = 0;
  int errors = 0;

  instr_decoder_if #(.DATA_W(16)) bus ();

  instr_decoder #(.DATA_W(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .fetchBus (bus),
    .alu_fn   (alu_fn),
    .pc_sel   (pc_sel),
    .pc_we    (pc_we),
    .rd       (rd),
    .ra       (ra),
    .rb       (rb),
    .imm      (imm),
    .imm_sel  (imm_sel),
    .reg_we   (reg_we),
    .flags_we (flags_we),
    .cin_use  (cin_use),
    .illegal  (illegal)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Starts in a FETCH cycle, acks immediately, returns sampling inside the EXEC cycle.
  task automatic runToExec(input logic [15:0] word);
    bus.instr   = word;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.instr   = 16'hFFFF;
    tick();
    #1;
  endtask

  task automatic test_reset();
    Reset       = 1'b1;
    bus.mem_ack = 1'b0;
    bus.instr   = 16'h0000;
    tick();
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (alu_fn !== FnACC) begin errors++; $display("FAIL reset_alu_fn: got %0d want %0d", alu_fn, FnACC); end
    checks++; if (pc_sel !== Lr) begin errors++; $display("FAIL reset_pc_sel: got %0d want %0d", pc_sel, Lr); end
    checks++; if ({pc_we, reg_we, flags_we, imm_sel, cin_use, illegal} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {pc_we, reg_we, flags_we, imm_sel, cin_use, illegal}); end
    checks++; if ({rd, ra, rb, imm} !== 25'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {rd, ra, rb, imm}); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL reset_release_mem_req: got %b want 1", bus.mem_req); end
  endtask

  task automatic test_fetch_wait();
    int reqCycles = 0;
    for (int i = 0; i < 4; i++) begin
      bus.instr   = (i == 3) ? 16'h2A5C : 16'h3330;
      bus.mem_ack = (i == 3);
      #1;
      if (bus.mem_req === 1'b1) reqCycles++;
      tick();
    end
    // DECODE: an ack here must be ignored.
    bus.mem_ack = 1'b1;
    bus.instr   = 16'h0000;
    #1;
    checks++; if (reqCycles !== 4) begin errors++; $display("FAIL fetch_req_cycles: got %0d want 4", reqCycles); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL decode_mem_req: got %b want 0", bus.mem_req); end
    checks++; if ({pc_we, reg_we, flags_we} !== 3'b000) begin errors++; $display("FAIL decode_we: got %b want 000", {pc_we, reg_we, flags_we}); end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    checks++; if (alu_fn !== FnADD) begin errors++; $display("FAIL add_alu_fn: got %0d want %0d", alu_fn, FnADD); end
    checks++; if ({rd, ra, rb} !== {3'd2, 3'd2, 3'd7}) begin errors++; $display("FAIL add_regs: got rd=%0d ra=%0d rb=%0d want 2 2 7", rd, ra, rb); end
    checks++; if ({reg_we, flags_we, imm_sel, cin_use} !== 4'b1100) begin errors++; $display("FAIL add_ctrl: got %b want 1100", {reg_we, flags_we, imm_sel, cin_use}); end
    checks++; if (pc_we !== 1'b1 || pc_sel !== Pc1) begin errors++; $display("FAIL add_pc: got we=%b sel=%0d want 1 %0d", pc_we, pc_sel, Pc1); end
    tick();
    checks++; if ({pc_we, reg_we, flags_we} !== 3'b000 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL after_exec: got we=%b req=%b want 000 1", {pc_we, reg_we, flags_we}, bus.mem_req); end
  endtask

  task automatic test_immediates();
    runToExec(16'h3330);
    checks++; if (imm !== 16'hFFF0) begin errors++; $display("FAIL addi_imm: got %h want fff0", imm); end
    checks++; if ({imm_sel, reg_we, flags_we, cin_use} !== 4'b1110 || alu_fn !== FnADD) begin errors++; $display("FAIL addi_ctrl: got %b alu=%0d want 1110 %0d", {imm_sel, reg_we, flags_we, cin_use}, alu_fn, FnADD); end
    checks++; if ({rd, ra} !== {3'd3, 3'd1}) begin errors++; $display("FAIL addi_regs: got rd=%0d ra=%0d want 3 1", rd, ra); end
    tick();
    runToExec(16'h4D7F);
    checks++; if (imm !== 16'h007F) begin errors++; $display("FAIL addib_imm: got %h want 007f", imm); end
    checks++; if ({rd, ra} !== {3'd5, 3'd5}) begin errors++; $display("FAIL addib_ra_rd: got rd=%0d ra=%0d want 5 5", rd, ra); end
    checks++; if ({imm_sel, reg_we, flags_we} !== 3'b111 || alu_fn !== FnADD) begin errors++; $display("FAIL addib_ctrl: got %b alu=%0d want 111 %0d", {imm_sel, reg_we, flags_we}, alu_fn, FnADD); end
    tick();
    runToExec(16'h4D80);
    checks++; if (imm !== 16'hFF80) begin errors++; $display("FAIL addib_neg_imm: got %h want ff80", imm); end
    tick();
  endtask

  task automatic test_carry_nop();
    runToExec(16'h4143);
    checks++; if ({cin_use, imm_sel} !== 2'b11 || imm !== 16'h0003) begin errors++; $display("FAIL adci: got cin=%b isel=%b imm=%h want 1 1 0003", cin_use, imm_sel, imm); end
    checks++; if ({rd, ra} !== {3'd1, 3'd2}) begin errors++; $display("FAIL adci_regs: got rd=%0d ra=%0d want 1 2", rd, ra); end
    tick();
    runToExec(16'h3CB8);
    checks++; if ({cin_use, imm_sel, reg_we} !== 3'b101) begin errors++; $display("FAIL adc_ctrl: got %b want 101", {cin_use, imm_sel, reg_we}); end
    checks++; if ({rd, ra, rb} !== {3'd4, 3'd5, 3'd6}) begin errors++; $display("FAIL adc_regs: got rd=%0d ra=%0d rb=%0d want 4 5 6", rd, ra, rb); end
    tick();
    runToExec(16'h0000);
    checks++; if ({reg_we, flags_we} !== 2'b00 || alu_fn !== FnACC) begin errors++; $display("FAIL nop_ctrl: got we=%b alu=%0d want 00 %0d", {reg_we, flags_we}, alu_fn, FnACC); end
    checks++; if (pc_we !== 1'b1 || pc_sel !== Pc1) begin errors++; $display("FAIL nop_pc: got we=%b sel=%0d want 1 %0d", pc_we, pc_sel, Pc1); end
    tick();
    checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL nop_pc_we_after: got %b want 0", pc_we); end
  endtask

  task automatic test_reset_in_decode();
    runToExec(16'h4D7F);
    tick();
    bus.instr   = 16'h2A5C;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    Reset       = 1'b1;
    tick();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_dec_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (alu_fn !== FnACC || pc_sel !== Lr) begin errors++; $display("FAIL rst_dec_sel: got alu=%0d pc=%0d want %0d %0d", alu_fn, pc_sel, FnACC, Lr); end
    checks++; if ({rd, ra, imm, imm_sel, pc_we, reg_we} !== 25'h0) begin errors++; $display("FAIL rst_dec_fields: got %h want 0", {rd, ra, imm, imm_sel, pc_we, reg_we}); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rst_dec_resume_req: got %b want 1", bus.mem_req); end
    runToExec(16'h0000);
    checks++; if (pc_we !== 1'b1 || pc_sel !== Pc1) begin errors++; $display("FAIL rst_dec_resume_exec: got we=%b sel=%0d want 1 %0d", pc_we, pc_sel, Pc1); end
    tick();
  endtask

  task automatic test_illegal();
    runToExec(16'hF800);
`ifdef ILLEGAL_TRAP_EN
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL trap_illegal: got %b want 1", illegal); end
    checks++; if ({pc_we, reg_we, flags_we} !== 3'b000) begin errors++; $display("FAIL trap_we: got %b want 000", {pc_we, reg_we, flags_we}); end
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1;
      tick();
      checks++; if ({bus.mem_req, illegal, pc_we} !== 3'b010) begin errors++; $display("FAIL trap_halt_%0d: got req/ill/pcwe=%b want 010", i, {bus.mem_req, illegal, pc_we}); end
    end
    bus.mem_ack = 1'b0;
    Reset       = 1'b1;
    tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL trap_reset_illegal: got %b want 0", illegal); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL trap_reset_req: got %b want 1", bus.mem_req); end
`else
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL unk_illegal: got %b want 0", illegal); end
    checks++; if ({pc_we, reg_we, flags_we} !== 3'b100 || alu_fn !== FnACC) begin errors++; $display("FAIL unk_nop: got we=%b alu=%0d want 100 %0d", {pc_we, reg_we, flags_we}, alu_fn, FnACC); end
    checks++; if (pc_sel !== Pc1) begin errors++; $display("FAIL unk_pc_sel: got %0d want %0d", pc_sel, Pc1); end
    tick();
    checks++; if (bus.mem_req !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL unk_resume: got req=%b ill=%b want 1 0", bus.mem_req, illegal); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_immediates();
    test_carry_nop();
    test_reset_in_decode();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required to finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction and immediate width.
REQ-002 SHALL have port Clock, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, meaning synchronous, active-high reset.
REQ-004 SHALL have port mem_req, output, 1, meaning instruction fetch request to the system bus.
REQ-005 SHALL have port mem_ack, input, 1, meaning fetch data valid on instr this cycle.
REQ-006 SHALL have port instr, input, DATA_W, meaning the fetched instruction word.
REQ-007 SHALL have port alu_fn, output, alu_functions_t, meaning the ALU function select.
REQ-008 SHALL have port pc_sel, output, pc_select_t, meaning the next-PC source.
REQ-009 SHALL have port pc_we, output, 1, meaning PC write enable.
REQ-010 SHALL have ports rd, ra and rb, each output, 3, meaning the destination and source register addresses.
REQ-011 SHALL have port imm, output, DATA_W, meaning the extended immediate.
REQ-012 SHALL have port imm_sel, output, 1, meaning the ALU B operand is imm when 1 and register rb when 0.
REQ-013 SHALL have ports reg_we, flags_we and cin_use, each output, 1, meaning register write enable, flag write enable and carry-in from flag C.
REQ-014 SHALL have port illegal, output, 1, meaning an unrecognised opcode was decoded.

Function
REQ-015 SHALL decode the instruction fields as: opcode instr[15:11]; rd [10:8]; ra [7:5]; rb [4:2]; imm5 [4:0]; imm8 [7:0].
REQ-016 SHALL implement the FSM states FETCH, DECODE and EXEC, plus HALT when the REQ-031 macro is defined; the reset state is FETCH.
REQ-017 SHALL, in FETCH, assert mem_req every cycle until mem_ack, capture instr into the IR on the mem_ack cycle, and go to DECODE.
REQ-018 SHALL ignore mem_ack outside FETCH and never capture the IR outside FETCH.
REQ-019 SHALL, in DECODE, register the fields and the control word from the IR, then go to EXEC after exactly 1 cycle.
REQ-020 SHALL, in EXEC, hold the control outputs for exactly 1 cycle, assert pc_we with pc_sel=Pc1, then return to FETCH.
REQ-021 SHALL require exactly 2 cycles from the mem_ack cycle to the EXEC cycle, inclusive of EXEC.
REQ-022 SHALL hold reg_we, flags_we and pc_we low in every state except EXEC.
REQ-023 SHALL decode ADD as: alu_fn=FnADD, imm_sel=0, reg_we=1, flags_we=1, cin_use=0.
REQ-024 SHALL decode ADDI as ADD with imm_sel=1 and imm = imm5 sign-extended to DATA_W.
REQ-025 SHALL decode ADC and ADCI as ADD and ADDI respectively, with cin_use=1.
REQ-026 SHALL decode ADDIB as: ra=rd, imm = imm8 sign-extended, imm_sel=1, alu_fn=FnADD, reg_we=1, flags_we=1.
REQ-027 SHALL decode NOP as: reg_we=0, flags_we=0, alu_fn=FnACC, and PC advance only.
REQ-028 SHALL treat any other opcode per REQ-031.

Reset
REQ-029 SHALL, when Reset is sampled high, set state=FETCH, IR=0, illegal=0, and all outputs to 0 (alu_fn=FnACC, pc_sel=Lr) on the next edge, overriding any transaction in flight.
REQ-030 SHALL keep mem_req low in the cycle after a Reset edge, and assert it from the first cycle with Reset low.

Configuration
REQ-031 SHALL use macro ILLEGAL_TRAP_EN: when defined, an unknown opcode sets illegal=1 in EXEC with no writes and pc_we=0, then enters HALT, leaving only on Reset; when undefined, an unknown opcode executes as NOP and illegal stays 0.

Structure
REQ-032 SHALL place alu_functions_t, pc_select_t, the opcode constants and the FSM state enum in package opcodes.
REQ-033 SHALL implement the combinational opcode-to-control-word table as sub-module instr_decode_rom; the FSM and registers stay in instr_decoder.

Verification
REQ-034 SHALL cover: mem_ack delayed 3 cycles -> mem_req high 4 cycles, IR captured only on the ack cycle.
REQ-035 SHALL cover: instr=16'h2A5C (ADD r2,r2,r7) -> EXEC: alu_fn=FnADD, rd=2, ra=2, rb=7, reg_we=1, imm_sel=0.
REQ-036 SHALL cover: ADDI with imm5=5'b10000 -> imm=16'hFFF0; ADDIB with imm8=8'h7F -> imm=16'h007F, ra=rd.
REQ-037 SHALL cover: ADCI -> cin_use=1; NOP -> reg_we=0 and pc_we=1 with pc_sel=Pc1.
REQ-038 SHALL cover: Reset asserted in DECODE -> next cycle in FETCH with all outputs 0 and mem_req=0, then fetch resumes.
REQ-039 SHALL cover: opcode 5'b11111 -> with ILLEGAL_TRAP_EN, illegal=1 and mem_req stays 0 until Reset; without it, behaves as NOP.
